// File: rtl/alu_serial_exec.sv
// Digit-serial ALU: one DIGIT-wide slice per cycle, LSB first, with a
// valid/ready handshake on both the operation input and the result output.
module alu_serial_exec #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       Operation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             op_err
);

  localparam int D  = WIDTH / DIGIT;
  localparam int CW = (D > 1) ? $clog2(D) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, res_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, zero_q, err_q, out_valid_q;

  logic             use_sub, legal, lt;
  logic [DIGIT-1:0] a_dig, b_raw, b_dig, slice;
  logic [DIGIT:0]   sum_w;
  logic [WIDTH-1:0] acc_d, final_d;

  // Operands shift right each RUN cycle, so the active slice is always the low digit.
  always_comb begin
    use_sub = (op_q == OP_SUB) || (op_q == OP_SLT);
    legal   = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_AND) ||
              (op_q == OP_OR)  || (op_q == OP_SLT);
    a_dig   = a_q[DIGIT-1:0];
    b_raw   = b_q[DIGIT-1:0];
    b_dig   = use_sub ? ~b_raw : b_raw;
    sum_w   = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
    case (op_q)
      OP_AND:  slice = a_dig & b_raw;
      OP_OR:   slice = a_dig | b_raw;
      default: slice = sum_w[DIGIT-1:0];
    endcase
    acc_d = (acc_q >> DIGIT) | (WIDTH'(slice) << (WIDTH - DIGIT));
    // Only meaningful on the last slice, where a_dig/b_raw hold the top digits.
    lt = (a_dig[DIGIT-1] ^ b_raw[DIGIT-1]) ? a_dig[DIGIT-1] : sum_w[DIGIT-1];
    if (!legal)
      final_d = '0;
    else if (op_q == OP_SLT)
      final_d = WIDTH'(lt);
    else
      final_d = acc_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q    <= Operation;
            a_q     <= A;
            b_q     <= B;
            acc_q   <= '0;
            cnt_q   <= '0;
            carry_q <= (Operation == OP_SUB) || (Operation == OP_SLT);
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          acc_q   <= acc_d;
          carry_q <= sum_w[DIGIT];
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(D - 1)) begin
            res_q       <= final_d;
            zero_q      <= (final_d == '0);
            err_q       <= !legal;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // No accept on the handshake edge; IDLE is entered first.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign Result    = res_q;
  assign Zero      = zero_q;
  assign op_err    = err_q;

endmodule

// File: tb/tb_alu_serial_exec.sv
// Directed bench for alu_serial_exec (WIDTH=32, DIGIT=8): latency, results,
// backpressure, mid-run reset and illegal codes against hand-computed values.
module tb_alu_serial_exec;

  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready;
  logic        in_ready, out_valid, Zero, op_err;
  logic [2:0]  Operation;
  logic [31:0] A, B, Result;
  int checks = 0;
  int failures = 0;

  alu_serial_exec #(.WIDTH(32), .DIGIT(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Operation(Operation), .A(A), .B(B), .out_valid(out_valid),
    .out_ready(out_ready), .Result(Result), .Zero(Zero), .op_err(op_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op at the next edge, scramble inputs, wait for completion, check
  // latency and outputs, then take the result.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_zero, input logic exp_err);
    int n;
    @(negedge clk);
    in_valid = 1'b1; Operation = op; A = a; B = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; Operation = 3'b010; A = 32'hDEADBEEF; B = 32'h12345678;
    chk({name, "_in_ready_busy"}, {31'b0, in_ready}, 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, n, 32'd4);
    chk({name, "_result"}, Result, exp_res);
    chk({name, "_zero"}, {31'b0, Zero}, {31'b0, exp_zero});
    chk({name, "_op_err"}, {31'b0, op_err}, {31'b0, exp_err});
    $display("txn %s op=%b A=%h B=%h result=%h zero=%b err=%b", name, op, a, b, Result, Zero, op_err);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_out_valid_clr"}, {31'b0, out_valid}, 32'd0);
    chk({name, "_in_ready_back"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    Operation = 3'b000; A = '0; B = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", Result, 32'd0);
    chk("rst_zero", {31'b0, Zero}, 32'd0);
    chk("rst_op_err", {31'b0, op_err}, 32'd0);

    run_op("add",      3'b000, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0);
    run_op("add_wrap", 3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0);
    run_op("sub_eq",   3'b001, 32'd5,        32'd5,        32'h00000000, 1'b1, 1'b0);
    run_op("sub_neg",  3'b001, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1'b0);
    run_op("slt_neg",  3'b101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0);
    run_op("slt_ovf",  3'b101, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0);
    run_op("slt_pos",  3'b101, 32'h00000001, 32'h00000002, 32'h00000001, 1'b0, 1'b0);
    run_op("and",      3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0);
    run_op("or",       3'b011, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0);
    run_op("ill_100",  3'b100, 32'h12345678, 32'h1,        32'h00000000, 1'b1, 1'b1);
    run_op("ill_111",  3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1);
    run_op("sub_mix",  3'b001, 32'h12345678, 32'h00000679, 32'h12344FFF, 1'b0, 1'b0);

    // Backpressure: result held with a second op pending on in_valid.
    @(negedge clk);
    in_valid = 1'b1; Operation = 3'b000; A = 32'h00001000; B = 32'h00000234;
    @(posedge clk);
    @(negedge clk);
    Operation = 3'b001; A = 32'd9; B = 32'd9;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("bp_valid", {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_result_held", Result, 32'h00001234);
      chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
      chk("bp_valid_held", {31'b0, out_valid}, 32'd1);
    end
    $display("txn backpressure result=%h", Result);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("bp_no_accept", {31'b0, in_ready}, 32'd1);
    chk("bp_valid_clr", {31'b0, out_valid}, 32'd0);
    chk("bp_result_after", Result, 32'h00001234);

    // Reset two RUN edges into an op: abandoned, outputs back to reset values.
    @(negedge clk);
    in_valid = 1'b1; Operation = 3'b011; A = 32'h0F0F0F0F; B = 32'h1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_result", Result, 32'd0);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      chk("midrst_no_valid", {31'b0, out_valid}, 32'd0);
    end
    $display("txn midrun_reset result=%h in_ready=%b", Result, in_ready);

    run_op("post_rst", 3'b100, 32'h0, 32'h0, 32'h00000000, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
